// File: rtl/negedge_reg_file.sv
// ============================================================================
// Module   : negedge_reg_file
// Brief    : DEPTH x WIDTH register bank, one write port, two combinational
//            read ports, optional write-to-read bypass and NZP flags.
//            All state changes on the falling edge of Clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module negedge_reg_file #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    input  logic             WE,
    input  logic [AW-1:0]    DR,
    input  logic             LD_CC,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    output logic [WIDTH-1:0] SR1_out,
    output logic [WIDTH-1:0] SR2_out,
    output logic [2:0]       NZP
);

    localparam logic [2:0] C_NZP_N = 3'b100;
    localparam logic [2:0] C_NZP_Z = 3'b010;
    localparam logic [2:0] C_NZP_P = 3'b001;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [2:0]       nzp_q;
    logic [2:0]       nzp_d;

    always_comb begin
        regs_d = regs_q;
        if (WE) begin
            regs_d[DR] = D;
        end
    end

    always_comb begin
        nzp_d = nzp_q;
        if (LD_CC) begin
            if (D[WIDTH-1]) begin
                nzp_d = C_NZP_N;
            end else if (D == '0) begin
                nzp_d = C_NZP_Z;
            end else begin
                nzp_d = C_NZP_P;
            end
        end
    end

    // Reset wins over WE and LD_CC so no partial update survives it.
    always_ff @(negedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= C_NZP_Z;
        end else begin
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            // Forward the pending write so same-cycle consumers see it pre-edge.
            always_comb begin
                SR1_out = (WE && (SR1 == DR)) ? D : regs_q[SR1];
                SR2_out = (WE && (SR2 == DR)) ? D : regs_q[SR2];
            end
        end else begin : g_no_bypass
            always_comb begin
                SR1_out = regs_q[SR1];
                SR2_out = regs_q[SR2];
            end
        end
    endgenerate

    assign NZP = nzp_q;

endmodule

`default_nettype wire

// File: tb/tb_negedge_reg_file.sv
// ============================================================================
// Module   : tb_negedge_reg_file
// Brief    : Directed bench for negedge_reg_file, bypass and non-bypass builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_negedge_reg_file;

    logic        Clk;
    logic        Reset;
    logic [15:0] D;
    logic        WE;
    logic [2:0]  DR;
    logic        LD_CC;
    logic [2:0]  SR1;
    logic [2:0]  SR2;

    logic [15:0] sr1_b, sr2_b, sr1_n, sr2_n;
    logic [2:0]  nzp_b, nzp_n;

    int n_checks = 0;
    int n_errors = 0;

    negedge_reg_file #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .D(D), .WE(WE), .DR(DR), .LD_CC(LD_CC),
        .SR1(SR1), .SR2(SR2), .SR1_out(sr1_b), .SR2_out(sr2_b), .NZP(nzp_b)
    );

    negedge_reg_file #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(0)) u_dut_n (
        .Clk(Clk), .Reset(Reset), .D(D), .WE(WE), .DR(DR), .LD_CC(LD_CC),
        .SR1(SR1), .SR2(SR2), .SR1_out(sr1_n), .SR2_out(sr2_n), .NZP(nzp_n)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One full clock period ending just after the falling edge.
    task automatic tick();
        #5 Clk = 1'b1;
        #5 Clk = 1'b0;
        #1;
    endtask

    initial begin
        Clk = 1'b0; Reset = 1'b1; D = '0; WE = 1'b0; DR = '0;
        LD_CC = 1'b0; SR1 = '0; SR2 = '0;
        #2;

        // Reset with write and LD_CC requested: both must be ignored.
        Reset = 1'b0; WE = 1'b1; D = 16'hFFFF; DR = 3'd3; LD_CC = 1'b1; SR1 = 3'd3;
        tick();
        Reset = 1'b1; WE = 1'b0; LD_CC = 1'b0; #1;
        check("rst_sr1_b", sr1_b, 16'h0000);
        check("rst_sr1_n", sr1_n, 16'h0000);
        check("rst_nzp_b", {13'd0, nzp_b}, 16'h0002);
        check("rst_nzp_n", {13'd0, nzp_n}, 16'h0002);
        for (int a = 0; a < 8; a++) begin
            SR1 = a[2:0]; SR2 = a[2:0]; #1;
            check($sformatf("rst_r%0d_p1", a), sr1_b, 16'h0000);
            check($sformatf("rst_r%0d_p2", a), sr2_n, 16'h0000);
        end

        // Two writes, then read both ports.
        WE = 1'b1; DR = 3'd5; D = 16'h1234; tick();
        DR = 3'd2; D = 16'hABCD; tick();
        WE = 1'b0; SR1 = 3'd5; SR2 = 3'd2; #1;
        check("wr_sr1_b", sr1_b, 16'h1234);
        check("wr_sr2_b", sr2_b, 16'hABCD);
        check("wr_sr1_n", sr1_n, 16'h1234);
        check("wr_sr2_n", sr2_n, 16'hABCD);
        for (int a = 0; a < 8; a++) begin
            if (a != 5 && a != 2) begin
                SR1 = a[2:0]; #1;
                check($sformatf("wr_other_r%0d", a), sr1_n, 16'h0000);
            end
        end

        // Pre-edge bypass on both ports.
        WE = 1'b1; DR = 3'd4; D = 16'h00FF; SR1 = 3'd4; SR2 = 3'd4; #1;
        check("byp_sr1_b", sr1_b, 16'h00FF);
        check("byp_sr2_b", sr2_b, 16'h00FF);
        check("nobyp_sr1_n", sr1_n, 16'h0000);
        check("nobyp_sr2_n", sr2_n, 16'h0000);
        SR2 = 3'd5; #1;
        check("byp_sr2_other", sr2_b, 16'h1234);
        tick();
        WE = 1'b0; #1;
        check("byp_commit_b", sr1_b, 16'h00FF);
        check("byp_commit_n", sr1_n, 16'h00FF);

        // Condition codes without a register write.
        LD_CC = 1'b1; D = 16'h8000; tick();
        check("cc_neg", {13'd0, nzp_b}, 16'h0004);
        D = 16'h0000; tick();
        check("cc_zero", {13'd0, nzp_b}, 16'h0002);
        D = 16'h0001; tick();
        check("cc_pos", {13'd0, nzp_n}, 16'h0001);
        LD_CC = 1'b0; D = 16'h8000; tick();
        check("cc_hold", {13'd0, nzp_b}, 16'h0001);
        SR1 = 3'd4; SR2 = 3'd5; #1;
        check("cc_regs_r4", sr1_n, 16'h00FF);
        check("cc_regs_r5", sr2_n, 16'h1234);

        // Rising edge alone must not commit.
        WE = 1'b1; DR = 3'd6; D = 16'h5555; SR1 = 3'd6;
        #5 Clk = 1'b1;
        #10;
        check("rise_only_n", sr1_n, 16'h0000);
        Clk = 1'b0; #1;
        WE = 1'b0; #1;
        check("fall_commit_n", sr1_n, 16'h5555);
        check("fall_commit_b", sr1_b, 16'h5555);

        // Reset colliding with a write and LD_CC; reset is not asynchronous.
        WE = 1'b1; DR = 3'd7; D = 16'h7777; tick();
        D = 16'h1111; LD_CC = 1'b1; Reset = 1'b0; SR1 = 3'd7; SR2 = 3'd5; #1;
        check("rst_sync_r5", sr2_n, 16'h1234);
        check("rst_sync_r7", sr1_n, 16'h7777);
        check("rst_sync_nzp", {13'd0, nzp_n}, 16'h0001);
        tick();
        Reset = 1'b1; WE = 1'b0; LD_CC = 1'b0; #1;
        check("rst_mid_r7_b", sr1_b, 16'h0000);
        check("rst_mid_r7_n", sr1_n, 16'h0000);
        check("rst_mid_r5", sr2_b, 16'h0000);
        check("rst_mid_nzp", {13'd0, nzp_b}, 16'h0002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
